// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier feeding the register-file write port.
// One multiplier bit is consumed per RUN cycle; the product is written back in a single DONE cycle.
module seq_multiplier #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [WIDTH-1:0]  DATA1,
    input  logic [WIDTH-1:0]  DATA2,
    input  logic [ADDR_W-1:0] DESTADDR,
    output logic [WIDTH-1:0]  RESULT,
    output logic              OVF,
    output logic [ADDR_W-1:0] WRADDR,
    output logic              WRITE,
    output logic              BUSY
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [2*WIDTH-1:0]     acc_reg, acc_next;
    logic [2*WIDTH-1:0]     mcand_reg, mcand_next;
    logic [WIDTH-1:0]       mplier_reg, mplier_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [ADDR_W-1:0]      dest_reg, dest_next;
    logic [WIDTH-1:0]       result_reg, result_next;
    logic                   ovf_reg, ovf_next;
    logic [ADDR_W-1:0]      wraddr_reg, wraddr_next;
    logic                   write_reg, write_next;
    logic                   busy_reg, busy_next;
    logic [2*WIDTH-1:0]     sum;

    // Partial sum including this cycle's multiplier bit; on the last RUN edge it is the full product.
    assign sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        dest_next   = dest_reg;
        result_next = result_reg;
        ovf_next    = ovf_reg;
        wraddr_next = wraddr_reg;
        write_next  = 1'b0;
        busy_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    mcand_next  = {{WIDTH{1'b0}}, DATA1};
                    mplier_next = DATA2;
                    dest_next   = DESTADDR;
                    acc_next    = '0;
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    state_next  = RUN;
                end
            end
            RUN: begin
                busy_next   = 1'b1;
                acc_next    = sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    result_next = sum[WIDTH-1:0];
                    ovf_next    = |sum[2*WIDTH-1:WIDTH];
                    wraddr_next = dest_reg;
                    write_next  = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            dest_reg   <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            wraddr_reg <= '0;
            write_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            dest_reg   <= dest_next;
            result_reg <= result_next;
            ovf_reg    <= ovf_next;
            wraddr_reg <= wraddr_next;
            write_reg  <= write_next;
            busy_reg   <= busy_next;
        end
    end

    assign RESULT = result_reg;
    assign OVF    = ovf_reg;
    assign WRADDR = wraddr_reg;
    assign WRITE  = write_reg;
    assign BUSY   = busy_reg;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier against a plain a*b reference with a fixed
// 9-cycle busy window and a single write strobe on the last busy cycle.
module tb_seq_multiplier;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] destaddr;
    logic [7:0] result;
    logic       ovf;
    logic [2:0] wraddr;
    logic       write;
    logic       busy;

    typedef struct {
        int         cyc;
        logic [7:0] res;
        logic       ovf;
        logic [2:0] addr;
    } wr_t;

    wr_t wq[$];
    int  cyc;
    int  busy_n;
    int  n_cmp;
    int  n_bad;
    int  c0;

    seq_multiplier #(.WIDTH(8), .ADDR_W(3)) dut (
        .CLK(clk),
        .RESET(reset),
        .START(start),
        .DATA1(data1),
        .DATA2(data2),
        .DESTADDR(destaddr),
        .RESULT(result),
        .OVF(ovf),
        .WRADDR(wraddr),
        .WRITE(write),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change at negedge, outputs sampled at negedge (away from the active edge).
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (write) wq.push_back('{cyc, result, ovf, wraddr});
        if (busy) busy_n++;
    endtask

    task automatic begin_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        data1 = a;
        data2 = b;
        destaddr = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        data1 = 8'($urandom);
        data2 = 8'($urandom);
        destaddr = 3'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        int prod;
        prod = int'(a) * int'(b);
        wq.delete();
        busy_n = 0;
        begin_op(a, b, d);
        c0 = cyc;
        repeat (11) tick();
        check({tag, " writes"}, wq.size(), 1);
        if (wq.size() == 1) begin
            check({tag, " wcycle"}, wq[0].cyc, c0 + 8);
            check({tag, " result"}, wq[0].res, prod % 256);
            check({tag, " ovf"}, wq[0].ovf, prod > 255);
            check({tag, " wraddr"}, wq[0].addr, d);
        end
        check({tag, " busy_n"}, busy_n, 9);
        check({tag, " held"}, result, prod % 256);
        check({tag, " idle"}, busy, 0);
        $display("op %s: %0d*%0d -> reg %0d", tag, a, b, d);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        reset = 1'b1;
        start = 1'b0;
        data1 = '0;
        data2 = '0;
        destaddr = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst result", result, 0);
        check("rst ovf", ovf, 0);
        check("rst wraddr", wraddr, 0);
        check("rst write", write, 0);
        check("rst busy", busy, 0);

        run_op("3x5", 8'd3, 8'd5, 3'd2);
        run_op("20x20", 8'd20, 8'd20, 3'd7);
        run_op("ffxff", 8'hff, 8'hff, 3'd3);
        run_op("0xff", 8'h00, 8'hff, 3'd5);

        // START during RUN is ignored and not queued.
        wq.delete();
        begin_op(8'd4, 8'd6, 3'd6);
        tick();
        data1 = 8'd9;
        data2 = 8'd9;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        repeat (16) tick();
        check("ign writes", wq.size(), 1);
        if (wq.size() == 1) check("ign result", wq[0].res, 8'h18);
        $display("op ignored-start: 4*6 with 9*9 re-request");

        // Reset mid-RUN aborts without a write.
        wq.delete();
        begin_op(8'd7, 8'd7, 3'd4);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort result", result, 0);
        check("abort ovf", ovf, 0);
        check("abort wraddr", wraddr, 0);
        check("abort write", write, 0);
        repeat (12) tick();
        check("abort writes", wq.size(), 0);
        $display("op reset-abort: 7*7");
        run_op("2x3", 8'd2, 8'd3, 3'd5);

        // RESET together with START: reset wins.
        wq.delete();
        reset = 1'b1;
        data1 = 8'd5;
        data2 = 8'd5;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rststart busy", busy, 0);
        repeat (12) tick();
        check("rststart writes", wq.size(), 0);
        $display("op reset+start: 5*5");

        // Back-to-back: second START in the first IDLE cycle after DONE.
        wq.delete();
        busy_n = 0;
        begin_op(8'd2, 8'd3, 3'd1);
        c0 = cyc;
        repeat (9) tick();
        data1 = 8'd4;
        data2 = 8'd5;
        destaddr = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("b2b writes", wq.size(), 2);
        if (wq.size() == 2) begin
            check("b2b cyc0", wq[0].cyc, c0 + 8);
            check("b2b cyc1", wq[1].cyc, c0 + 18);
            check("b2b res0", wq[0].res, 8'h06);
            check("b2b res1", wq[1].res, 8'h14);
            check("b2b addr0", wq[0].addr, 1);
            check("b2b addr1", wq[1].addr, 4);
        end
        check("b2b busy_n", busy_n, 18);
        $display("op back-to-back: 2*3 then 4*5");

        for (int i = 0; i < 20; i++) begin
            run_op("rand", 8'($urandom), 8'($urandom), 3'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
